// File: rtl/dynamic_input_route_buffer_para.sv
// Input-port stage of the 3-way dynamic-network router: credit-flow FIFO,
// header route decode and packet-length tracking for the output-port stages.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module dynamic_input_route_buffer_para #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [`CHIP_ID_WIDTH-1:0] my_chip_id,
    input  logic [`XY_WIDTH-1:0]      my_loc_x,
    input  logic [`XY_WIDTH-1:0]      my_loc_y,
    input  logic [`DATA_WIDTH-1:0]    data_in,
    input  logic                      valid_in,
    output logic                      yummy_out,
    output logic [`DATA_WIDTH-1:0]    data_out,
    output logic                      valid_out,
    output logic                      route_req_0_out,
    output logic                      route_req_1_out,
    output logic                      route_req_2_out,
    output logic                      tail_out,
    input  logic                      thanks_0_in,
    input  logic                      thanks_1_in,
    input  logic                      thanks_2_in,
    output logic                      overflow_err
);
    localparam int DW     = `DATA_WIDTH;
    localparam int CW     = `CHIP_ID_WIDTH;
    localparam int XW     = `XY_WIDTH;
    localparam int LW     = `PAYLOAD_LEN;
    localparam int X_HI   = DW - CW - 1;
    localparam int Y_HI   = DW - CW - XW - 1;
    localparam int LEN_HI = DW - CW - 2 * XW - 4;

    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0]     ROUTE_0   = 2'd0;
    localparam logic [1:0]     ROUTE_1   = 2'd1;
    localparam logic [1:0]     ROUTE_2   = 2'd2;
    localparam logic [0:0]     ST_HEADER = 1'b0;
    localparam logic [0:0]     ST_BODY   = 1'b1;

    logic [DW-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             yummy_r;
    logic             overflow_r;
    logic [0:0]       state_r;
    logic [1:0]       route_r;
    logic [LW-1:0]    remaining_r;

    logic [DW-1:0]    head_s;
    logic             valid_s;
    logic             full_s;
    logic             any_thanks_s;
    logic             pop_s;
    logic             push_s;
    logic [CW-1:0]    head_chip_s;
    logic [XW-1:0]    head_x_s;
    logic [XW-1:0]    head_y_s;
    logic [LW-1:0]    head_len_s;
    logic [1:0]       decoded_s;
    logic [1:0]       req_route_s;
    logic             tail_s;

    assign head_s       = mem_r[rd_ptr_r];
    assign valid_s      = (count_r != '0);
    assign full_s       = (count_r == FULL_CNT);
    assign any_thanks_s = thanks_0_in | thanks_1_in | thanks_2_in;
    assign pop_s        = valid_s & any_thanks_s;
    assign push_s       = valid_in & (~full_s | pop_s);

    assign head_chip_s  = head_s[DW-1 -: CW];
    assign head_x_s     = head_s[X_HI -: XW];
    assign head_y_s     = head_s[Y_HI -: XW];
    assign head_len_s   = head_s[LEN_HI -: LW];

    // Route decode of the head flit when interpreted as a header
    always_comb begin
        decoded_s = ROUTE_2;
        if ((head_chip_s == my_chip_id) && (head_x_s == my_loc_x) && (head_y_s == my_loc_y)) begin
            decoded_s = ROUTE_0;
        end else if ((head_chip_s == my_chip_id) && (head_x_s != my_loc_x)) begin
            decoded_s = ROUTE_1;
        end else begin
            decoded_s = ROUTE_2;
        end
    end

    // Body flits follow the route latched from their header, not their own bits
    always_comb begin
        req_route_s = decoded_s;
        tail_s      = 1'b0;
        if (state_r == ST_BODY) begin
            req_route_s = route_r;
            tail_s      = (remaining_r == LW'(1));
        end else begin
            req_route_s = decoded_s;
            tail_s      = (head_len_s == '0);
        end
    end

    assign valid_out       = valid_s;
    assign data_out        = valid_s ? head_s : '0;
    assign route_req_0_out = valid_s & (req_route_s == ROUTE_0);
    assign route_req_1_out = valid_s & (req_route_s == ROUTE_1);
    assign route_req_2_out = valid_s & (req_route_s == ROUTE_2);
    assign tail_out        = valid_s & tail_s;
    assign yummy_out       = yummy_r;
    assign overflow_err    = overflow_r;

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // FIFO pointers, occupancy, credit return and sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            yummy_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            yummy_r <= pop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (valid_in && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // HEADER/BODY tracking of the packet currently at the FIFO head
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_HEADER;
            route_r     <= ROUTE_0;
            remaining_r <= '0;
        end else if (pop_s) begin
            case (state_r)
                ST_HEADER: begin
                    if (head_len_s != '0) begin
                        route_r     <= decoded_s;
                        remaining_r <= head_len_s;
                        state_r     <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    remaining_r <= remaining_r - LW'(1);
                    if (remaining_r == LW'(1)) begin
                        state_r <= ST_HEADER;
                    end
                end
                default: state_r <= ST_HEADER;
            endcase
        end
    end

    dynamic_input_route_buffer_para_checker u_checker (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid     (valid_s),
        .route_req ({route_req_2_out, route_req_1_out, route_req_0_out}),
        .thanks    ({thanks_2_in, thanks_1_in, thanks_0_in})
    );

endmodule

// Protocol checks on the output-port handshake; ignored by synthesis.
module dynamic_input_route_buffer_para_checker (
    input logic       clk,
    input logic       reset_n,
    input logic       valid,
    input logic [2:0] route_req,
    input logic [2:0] thanks
);
    // A head flit requests exactly one route; an empty FIFO requests none
    a_one_req: assert property (@(posedge clk) disable iff (!reset_n)
        valid |-> $onehot(route_req));
    a_no_req_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !valid |-> (route_req == 3'b000));
    a_thanks_legal: assert property (@(posedge clk) disable iff (!reset_n)
        (valid && (thanks != 3'b000)) |-> ($onehot(thanks) && ((thanks & ~route_req) == 3'b000)));
endmodule

// File: tb/tb_dynamic_input_route_buffer_para.sv
// Directed bench for the router input buffer: reset, routing, packet tails,
// overflow handling, back-to-back packets and reset in the middle of a packet.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif

module tb_dynamic_input_route_buffer_para;
    logic        clk;
    logic        reset_n;
    logic [13:0] my_chip_id;
    logic [7:0]  my_loc_x;
    logic [7:0]  my_loc_y;
    logic [63:0] data_in;
    logic        valid_in;
    logic        yummy_out;
    logic [63:0] data_out;
    logic        valid_out;
    logic        route_req_0_out;
    logic        route_req_1_out;
    logic        route_req_2_out;
    logic        tail_out;
    logic        thanks_0_in;
    logic        thanks_1_in;
    logic        thanks_2_in;
    logic        overflow_err;

    int checks = 0;
    int passed = 0;

    dynamic_input_route_buffer_para #(.DEPTH(4), .PTR_W(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .my_chip_id      (my_chip_id),
        .my_loc_x        (my_loc_x),
        .my_loc_y        (my_loc_y),
        .data_in         (data_in),
        .valid_in        (valid_in),
        .yummy_out       (yummy_out),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .route_req_0_out (route_req_0_out),
        .route_req_1_out (route_req_1_out),
        .route_req_2_out (route_req_2_out),
        .tail_out        (tail_out),
        .thanks_0_in     (thanks_0_in),
        .thanks_1_in     (thanks_1_in),
        .thanks_2_in     (thanks_2_in),
        .overflow_err    (overflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Header layout: chip, x, y, 3 fbits, len, then payload tag bits
    function automatic logic [63:0] hdr(input logic [13:0] c, input logic [7:0] x,
                                        input logic [7:0] y, input logic [7:0] len,
                                        input logic [22:0] tag);
        return {c, x, y, 3'b000, len, tag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        valid_in    = 1'b0;
        data_in     = 64'd0;
        thanks_0_in = 1'b0;
        thanks_1_in = 1'b0;
        thanks_2_in = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (5) tick();
        checks++;
        if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out);
        else passed++;
        checks++;
        if ({route_req_2_out, route_req_1_out, route_req_0_out} !== 3'b000)
            $display("FAIL reset_req: got %b expected 000", {route_req_2_out, route_req_1_out, route_req_0_out});
        else passed++;
        checks++;
        if (yummy_out !== 1'b0) $display("FAIL reset_yummy: got %b expected 0", yummy_out);
        else passed++;
        checks++;
        if (overflow_err !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow_err);
        else passed++;
    endtask

    task automatic test_single();
        logic [63:0] f;
        f = hdr(14'd0, 8'd1, 8'd1, 8'd0, 23'h11);
        data_in = f; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        checks++;
        if ({valid_out, route_req_2_out, route_req_1_out, route_req_0_out, tail_out} !== 5'b10011)
            $display("FAIL single_head: got %b expected 10011",
                     {valid_out, route_req_2_out, route_req_1_out, route_req_0_out, tail_out});
        else passed++;
        checks++;
        if (data_out !== f) $display("FAIL single_data: got %h expected %h", data_out, f);
        else passed++;
        checks++;
        if (yummy_out !== 1'b0) $display("FAIL single_early_yummy: got %b expected 0", yummy_out);
        else passed++;
        thanks_0_in = 1'b1;
        tick();
        thanks_0_in = 1'b0;
        checks++;
        if ({yummy_out, valid_out} !== 2'b10)
            $display("FAIL single_pop: got yummy,valid=%b expected 10", {yummy_out, valid_out});
        else passed++;
        tick();
        checks++;
        if (yummy_out !== 1'b0) $display("FAIL single_yummy_pulse: got %b expected 0", yummy_out);
        else passed++;
    endtask

    task automatic test_multi();
        logic [63:0] f [3];
        logic [2:0]  tails;
        logic [63:0] g;
        f[0] = hdr(14'd0, 8'd3, 8'd1, 8'd2, 23'h21);
        f[1] = hdr(14'd0, 8'd1, 8'd1, 8'd0, 23'h22);
        f[2] = hdr(14'd0, 8'd1, 8'd1, 8'd0, 23'h23);
        tails = 3'b100;
        for (int i = 0; i < 3; i++) begin
            data_in = f[i]; valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({route_req_2_out, route_req_1_out, route_req_0_out, tail_out} !== {3'b010, tails[i]})
                $display("FAIL multi_req_tail flit %0d: got %b expected %b", i,
                         {route_req_2_out, route_req_1_out, route_req_0_out, tail_out}, {3'b010, tails[i]});
            else passed++;
            checks++;
            if (data_out !== f[i]) $display("FAIL multi_data flit %0d: got %h expected %h", i, data_out, f[i]);
            else passed++;
            thanks_1_in = 1'b1;
            tick();
            checks++;
            if (yummy_out !== 1'b1) $display("FAIL multi_yummy flit %0d: got %b expected 1", i, yummy_out);
            else passed++;
        end
        thanks_1_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) $display("FAIL multi_empty: got %b expected 0", valid_out);
        else passed++;
        g = hdr(14'd0, 8'd1, 8'd1, 8'd0, 23'h24);
        data_in = g; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        checks++;
        if ({route_req_2_out, route_req_1_out, route_req_0_out, tail_out} !== 4'b0011)
            $display("FAIL multi_back_to_header: got %b expected 0011",
                     {route_req_2_out, route_req_1_out, route_req_0_out, tail_out});
        else passed++;
        thanks_0_in = 1'b1;
        tick();
        thanks_0_in = 1'b0;
    endtask

    task automatic test_overflow();
        logic [63:0] g [5];
        for (int i = 0; i < 5; i++) g[i] = hdr(14'd0, 8'd1, 8'd1, 8'd0, 23'h30 + 23'(i));
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data_in = g[i]; valid_in = 1'b1;
            tick();
        end
        checks++;
        if ({valid_out, overflow_err} !== 2'b10)
            $display("FAIL ovf_full_no_err: got valid,ovf=%b expected 10", {valid_out, overflow_err});
        else passed++;
        data_in = g[4];
        tick();
        valid_in = 1'b0;
        checks++;
        if (overflow_err !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow_err);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out !== g[i]) $display("FAIL ovf_drain %0d: got %h expected %h", i, data_out, g[i]);
            else passed++;
            thanks_0_in = 1'b1;
            tick();
        end
        thanks_0_in = 1'b0;
        checks++;
        if ({valid_out, overflow_err} !== 2'b01)
            $display("FAIL ovf_dropped_sticky: got valid,ovf=%b expected 01", {valid_out, overflow_err});
        else passed++;

        do_reset();
        for (int i = 0; i < 4; i++) begin
            data_in = g[i]; valid_in = 1'b1;
            tick();
        end
        data_in = g[4]; thanks_0_in = 1'b1;
        tick();
        valid_in = 1'b0; thanks_0_in = 1'b0;
        checks++;
        if ({overflow_err, yummy_out} !== 2'b01)
            $display("FAIL ovf_push_pop_full: got ovf,yummy=%b expected 01", {overflow_err, yummy_out});
        else passed++;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (data_out !== g[i]) $display("FAIL ovf_accept_drain %0d: got %h expected %h", i, data_out, g[i]);
            else passed++;
            thanks_0_in = 1'b1;
            tick();
        end
        thanks_0_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) $display("FAIL ovf_accept_empty: got %b expected 0", valid_out);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] f [3];
        logic [2:0]  tails;
        f[0] = hdr(14'd0, 8'd1, 8'd2, 8'd1, 23'h41);
        f[1] = hdr(14'd0, 8'd3, 8'd1, 8'd0, 23'h42);
        f[2] = hdr(14'd5, 8'd1, 8'd1, 8'd0, 23'h43);
        tails = 3'b110;
        for (int i = 0; i < 3; i++) begin
            data_in = f[i]; valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({valid_out, route_req_2_out, route_req_1_out, route_req_0_out, tail_out} !== {4'b1100, tails[i]})
                $display("FAIL b2b flit %0d: got %b expected %b", i,
                         {valid_out, route_req_2_out, route_req_1_out, route_req_0_out, tail_out},
                         {4'b1100, tails[i]});
            else passed++;
            thanks_2_in = 1'b1;
            tick();
        end
        thanks_2_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", valid_out);
        else passed++;
    endtask

    task automatic test_reset_mid_body();
        logic [63:0] f [4];
        logic [63:0] g;
        f[0] = hdr(14'd0, 8'd3, 8'd1, 8'd3, 23'h51);
        for (int i = 1; i < 4; i++) f[i] = hdr(14'd0, 8'd1, 8'd1, 8'd0, 23'h51 + 23'(i));
        for (int i = 0; i < 4; i++) begin
            data_in = f[i]; valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        thanks_1_in = 1'b1;
        repeat (2) tick();
        thanks_1_in = 1'b0;
        checks++;
        if ({route_req_2_out, route_req_1_out, route_req_0_out, tail_out} !== 4'b0100)
            $display("FAIL mid_body_state: got %b expected 0100",
                     {route_req_2_out, route_req_1_out, route_req_0_out, tail_out});
        else passed++;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({valid_out, route_req_2_out, route_req_1_out, route_req_0_out, tail_out, yummy_out} !== 6'b000000)
            $display("FAIL mid_reset_outputs: got %b expected 000000",
                     {valid_out, route_req_2_out, route_req_1_out, route_req_0_out, tail_out, yummy_out});
        else passed++;
        checks++;
        if (data_out !== 64'd0) $display("FAIL mid_reset_data: got %h expected 0", data_out);
        else passed++;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        g = hdr(14'd0, 8'd1, 8'd1, 8'd0, 23'h5F);
        data_in = g; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        checks++;
        if ({route_req_2_out, route_req_1_out, route_req_0_out, tail_out} !== 4'b0011)
            $display("FAIL post_reset_header: got %b expected 0011",
                     {route_req_2_out, route_req_1_out, route_req_0_out, tail_out});
        else passed++;
        checks++;
        if (data_out !== g) $display("FAIL post_reset_data: got %h expected %h", data_out, g);
        else passed++;
        thanks_0_in = 1'b1;
        tick();
        thanks_0_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) $display("FAIL post_reset_empty: got %b expected 0", valid_out);
        else passed++;
    endtask

    initial begin
        reset_n     = 1'b0;
        my_chip_id  = 14'd0;
        my_loc_x    = 8'd1;
        my_loc_y    = 8'd1;
        data_in     = 64'd0;
        valid_in    = 1'b0;
        thanks_0_in = 1'b0;
        thanks_1_in = 1'b0;
        thanks_2_in = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_overflow();
        test_back_to_back();
        test_reset_mid_body();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
